ex_dispatch: RTL
================

Name: ex_dispatch

Overview:
- Execute stage, directly downstream of the issue stage.
- Consumes the registered is_ex_* bundle and routes each operation by functional-unit code:
  - single-cycle ALU/shifter
  - memory address generator
  - pipelined multiplier
- ALU and multiplier share one writeback port, arbitrated here; a one-entry skid buffer absorbs collisions.
- Each committed register write is reported back to the scoreboard so the pending bit clears.

Parameters:
- MUL_LAT, 3, multiplier pipeline depth in cycles (2..6).
- DW, 32, datapath width.

Ports:
- clock  in  1  clock
- reset  in  1  async active-low reset
- is_ex_unidadefuncional  in  2  unit code: 00 bubble, 01 ALU/shift, 10 memory, 11 multiplier
- is_ex_selalushift  in  1  0 = ALU result, 1 = shifter result
- is_ex_selimregb  in  1  1 = operand B is is_ex_imedext
- is_ex_aluop  in  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 nor, 110 slt, 111 pass-B
- is_ex_unsig  in  1  unsigned compare/multiply; suppresses overflow detection
- is_ex_shiftop  in  2  00 sll, 01 srl, 10 sra, 11 rotate-right
- is_ex_shiftamt  in  5  shift amount
- is_ex_rega, is_ex_regb, is_ex_imedext  in  DW  operands
- is_ex_readmem, is_ex_writemem, is_ex_selwsource  in  1  memory controls, forwarded
- is_ex_regdest  in  5  destination register
- is_ex_writereg, is_ex_writeov  in  1  write enable; write-only-if-no-overflow
- ex_is_stall  out  1  upstream must hold the bundle
- ex_mem_valid  out  1  memory op valid
- ex_mem_addr  out  DW  rega + imedext
- ex_mem_wdata  out  DW  regb
- ex_mem_readmem, ex_mem_writemem, ex_mem_selwsource  out  1  forwarded controls
- ex_mem_regdest  out  5  forwarded destination
- ex_mem_writereg  out  1  forwarded write enable
- ex_wb_valid  out  1  writeback valid
- ex_wb_regdest  out  5  writeback destination
- ex_wb_data  out  DW  writeback data
- ex_sb_clr  out  1  scoreboard clear strobe
- ex_sb_addr  out  5  register to clear
- ex_overflow  out  1  one-cycle pulse on signed overflow
- ex_illegal  out  1  one-cycle pulse on unsupported unit code

Behaviour:
- Reset: every output register is 0; skid empty; multiplier pipeline valid bits cleared. Reset mid-operation discards all in-flight results and issues no ex_sb_clr.
- Input sampling: the bundle is sampled on a clock edge only when ex_is_stall = 0. Code 00 has no effect.
- ex_is_stall: combinational, equals skid-valid.
- Operand B: imedext if selimregb = 1, else regb.
- Arithmetic:
  - add/sub are DW-bit wrap-around.
  - Signed overflow is computed only when unsig = 0 and aluop is add or sub.
  - slt gives 1/0, signed or unsigned per unsig.
  - sra sign-fills; rotate uses shiftamt mod 32.
- ALU path (01): result is ready 1 cycle after sampling.
  - writeov = 1 with overflow: no write, no ex_sb_clr, ex_overflow pulses. The pending bit stays owned by the overflow handler.
  - writereg = 0: completes silently.
- Memory path (10): ex_mem_* is registered 1 cycle after sampling; ex_mem_valid pulses for 1 cycle. No writeback or scoreboard action here; the memory stage owns the completion.
- Multiplier (11):
  - Fully pipelined, accepts 1 op/cycle; result is the low DW bits of rega*B.
  - Completes exactly MUL_LAT cycles after sampling.
  - Never stalls, including while ex_is_stall = 1.
- Writeback arbitration (per cycle), priority multiplier > skid > fresh ALU result:
  - A fresh ALU result blocked by a multiplier completion or by an occupied skid is loaded into the skid.
  - The skid drains on the first cycle with no multiplier completion.
  - Ops with writereg = 0 never occupy the writeback port.
- Scoreboard clear: ex_sb_clr/ex_sb_addr equal ex_wb_valid/ex_wb_regdest in the same cycle.
- Ordering: per destination, results may complete out of issue order; WAW is the issue stage's responsibility.

Optional Feature:
- EX_MULT_EN defined: multiplier as described.
- EX_MULT_EN undefined:
  - No multiplier logic; code 11 is treated as a bubble and ex_illegal pulses.
  - The skid is never loaded, so ex_is_stall is constant 0.

Test Plan:
- Reset, then ALU add rega=5, imm=7, selimregb=1, regdest=3 -> next cycle ex_wb_valid=1, data=12, ex_sb_clr=1, ex_sb_addr=3.
- Signed add 0x7FFFFFFF + 1 with writeov=1, unsig=0 -> ex_overflow pulse, ex_wb_valid=0, ex_sb_clr=0; same op with unsig=1 -> writes 0x80000000.
- Multiplier 6*7 to r4 at cycle t, then ALU or 1|2 to r5 timed to complete at t+3 (MUL_LAT=3):
  - cycle t+3: wb r4=42;
  - ex_is_stall=1 for exactly 1 cycle;
  - cycle t+4: wb r5=3.
- Load with rega=0x100, imm=0xFFFFFFFC -> ex_mem_addr=0xFC, ex_mem_valid 1-cycle pulse, no ex_wb_valid.
- Shifts on 0x80000001 with shiftamt=1:
  - sra -> 0xC0000000
  - srl -> 0x40000000
  - rotate -> 0xC0000000
  - sll -> 0x00000002
- Assert reset with 2 multiplies in flight -> no writeback after release, all outputs 0; without EX_MULT_EN, code 11 -> ex_illegal pulse, no writeback.

Source files
------------

// File: rtl/ex_dispatch_if.sv
// ex_dispatch_if: issue-to-execute bundle plus execute-stage result buses.
// master = issue/downstream side, slave = ex_dispatch.
interface ex_dispatch_if #(
    parameter int DW = 32
);
    logic [1:0]    is_ex_unidadefuncional;
    logic          is_ex_selalushift;
    logic          is_ex_selimregb;
    logic [2:0]    is_ex_aluop;
    logic          is_ex_unsig;
    logic [1:0]    is_ex_shiftop;
    logic [4:0]    is_ex_shiftamt;
    logic [DW-1:0] is_ex_rega;
    logic [DW-1:0] is_ex_regb;
    logic [DW-1:0] is_ex_imedext;
    logic          is_ex_readmem;
    logic          is_ex_writemem;
    logic          is_ex_selwsource;
    logic [4:0]    is_ex_regdest;
    logic          is_ex_writereg;
    logic          is_ex_writeov;

    logic          ex_is_stall;
    logic          ex_mem_valid;
    logic [DW-1:0] ex_mem_addr;
    logic [DW-1:0] ex_mem_wdata;
    logic          ex_mem_readmem;
    logic          ex_mem_writemem;
    logic          ex_mem_selwsource;
    logic [4:0]    ex_mem_regdest;
    logic          ex_mem_writereg;
    logic          ex_wb_valid;
    logic [4:0]    ex_wb_regdest;
    logic [DW-1:0] ex_wb_data;
    logic          ex_sb_clr;
    logic [4:0]    ex_sb_addr;
    logic          ex_overflow;
    logic          ex_illegal;

    modport master (
        output is_ex_unidadefuncional, is_ex_selalushift, is_ex_selimregb,
        output is_ex_aluop, is_ex_unsig, is_ex_shiftop, is_ex_shiftamt,
        output is_ex_rega, is_ex_regb, is_ex_imedext,
        output is_ex_readmem, is_ex_writemem, is_ex_selwsource,
        output is_ex_regdest, is_ex_writereg, is_ex_writeov,
        input  ex_is_stall,
        input  ex_mem_valid, ex_mem_addr, ex_mem_wdata,
        input  ex_mem_readmem, ex_mem_writemem, ex_mem_selwsource,
        input  ex_mem_regdest, ex_mem_writereg,
        input  ex_wb_valid, ex_wb_regdest, ex_wb_data,
        input  ex_sb_clr, ex_sb_addr, ex_overflow, ex_illegal
    );

    modport slave (
        input  is_ex_unidadefuncional, is_ex_selalushift, is_ex_selimregb,
        input  is_ex_aluop, is_ex_unsig, is_ex_shiftop, is_ex_shiftamt,
        input  is_ex_rega, is_ex_regb, is_ex_imedext,
        input  is_ex_readmem, is_ex_writemem, is_ex_selwsource,
        input  is_ex_regdest, is_ex_writereg, is_ex_writeov,
        output ex_is_stall,
        output ex_mem_valid, ex_mem_addr, ex_mem_wdata,
        output ex_mem_readmem, ex_mem_writemem, ex_mem_selwsource,
        output ex_mem_regdest, ex_mem_writereg,
        output ex_wb_valid, ex_wb_regdest, ex_wb_data,
        output ex_sb_clr, ex_sb_addr, ex_overflow, ex_illegal
    );
endinterface

// File: rtl/ex_dispatch.sv
// ex_dispatch: execute stage routing ALU/shift, address generation and multiply.
// Define EX_MULT_EN to build the pipelined multiplier and the writeback skid.
module ex_dispatch #(
    parameter int MUL_LAT = 3,
    parameter int DW      = 32
) (
    input logic          clock,
    input logic          reset,
    ex_dispatch_if.slave bus
);

    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic [4:0]    amt;
    logic          fire;
    logic          is_alu;
    logic          is_mem;
    logic          is_mul;

    assign op_a   = bus.is_ex_rega;
    assign op_b   = bus.is_ex_selimregb ? bus.is_ex_imedext : bus.is_ex_regb;
    assign amt    = bus.is_ex_shiftamt;
    assign is_alu = bus.is_ex_unidadefuncional == 2'b01;
    assign is_mem = bus.is_ex_unidadefuncional == 2'b10;
    assign is_mul = bus.is_ex_unidadefuncional == 2'b11;

    logic [DW-1:0] sum;
    logic [DW-1:0] diff;
    logic          lt;
    logic          ovf;
    logic [DW-1:0] alu_res;
    logic [DW-1:0] sh_res;
    logic [DW-1:0] result;
    logic          alu_wr;

    assign sum  = op_a + op_b;
    assign diff = op_a - op_b;
    assign lt   = bus.is_ex_unsig ? (op_a < op_b)
                                  : ($signed(op_a) < $signed(op_b));

    always_comb begin
        ovf = 1'b0;
        if (!bus.is_ex_unsig && !bus.is_ex_selalushift) begin
            if (bus.is_ex_aluop == 3'b000)
                ovf = (op_a[DW-1] == op_b[DW-1]) && (sum[DW-1] != op_a[DW-1]);
            else if (bus.is_ex_aluop == 3'b001)
                ovf = (op_a[DW-1] != op_b[DW-1]) && (diff[DW-1] != op_a[DW-1]);
        end
    end

    always_comb begin
        alu_res = '0;
        unique case (bus.is_ex_aluop)
            3'b000:  alu_res = sum;
            3'b001:  alu_res = diff;
            3'b010:  alu_res = op_a & op_b;
            3'b011:  alu_res = op_a | op_b;
            3'b100:  alu_res = op_a ^ op_b;
            3'b101:  alu_res = ~(op_a | op_b);
            3'b110:  alu_res = {{(DW-1){1'b0}}, lt};
            default: alu_res = op_b;
        endcase
    end

    // Shifts act on operand A; a rotate by 0 degenerates to A (A << DW is 0).
    always_comb begin
        sh_res = '0;
        unique case (bus.is_ex_shiftop)
            2'b00:   sh_res = op_a << amt;
            2'b01:   sh_res = op_a >> amt;
            2'b10:   sh_res = $signed(op_a) >>> amt;
            default: sh_res = (op_a >> amt) | (op_a << (DW - int'(amt)));
        endcase
    end

    assign result = bus.is_ex_selalushift ? sh_res : alu_res;
    assign alu_wr = bus.is_ex_writereg && !(bus.is_ex_writeov && ovf);

    logic          alu_v;
    logic [4:0]    alu_rd;
    logic [DW-1:0] alu_d;
    logic          mul_done;
    logic [4:0]    mul_rd;
    logic [DW-1:0] mul_d;
    logic          skid_v;
    logic [4:0]    skid_rd;
    logic [DW-1:0] skid_d;
    logic          g_alu;
    logic          g_skid;
    logic          wb_v;
    logic [4:0]    wb_rd;
    logic [DW-1:0] wb_d;
    logic          alu_blk;
    logic          alu_to_skid;

    assign fire = !skid_v;

    always_comb begin
        wb_v   = 1'b1;
        wb_rd  = '0;
        wb_d   = '0;
        g_alu  = 1'b0;
        g_skid = 1'b0;
        priority case (1'b1)
            mul_done: begin
                wb_rd = mul_rd;
                wb_d  = mul_d;
            end
            skid_v: begin
                g_skid = 1'b1;
                wb_rd  = skid_rd;
                wb_d   = skid_d;
            end
            alu_v: begin
                g_alu = 1'b1;
                wb_rd = alu_rd;
                wb_d  = alu_d;
            end
            default: wb_v = 1'b0;
        endcase
    end

    assign alu_blk     = alu_v && !g_alu;
    assign alu_to_skid = alu_blk && (g_skid || !skid_v);

    // A blocked result stays here only while the skid is full and stalled.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            alu_v  <= 1'b0;
            alu_rd <= '0;
            alu_d  <= '0;
        end else if (fire) begin
            alu_v  <= is_alu && alu_wr;
            alu_rd <= bus.is_ex_regdest;
            alu_d  <= result;
        end else if (alu_to_skid) begin
            alu_v  <= 1'b0;
        end
    end

`ifdef EX_MULT_EN
    logic [MUL_LAT-1:0] mv;
    logic [4:0]         mrd [MUL_LAT];
    logic [DW-1:0]      md  [MUL_LAT];
    logic [DW-1:0]      prod;

    assign prod = op_a * op_b;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) mv <= '0;
        else mv <= {mv[MUL_LAT-2:0], fire && is_mul && bus.is_ex_writereg};
    end

    always_ff @(posedge clock) begin
        mrd[0] <= bus.is_ex_regdest;
        md[0]  <= prod;
        for (int i = 1; i < MUL_LAT; i++) begin
            mrd[i] <= mrd[i-1];
            md[i]  <= md[i-1];
        end
    end

    assign mul_done = mv[MUL_LAT-1];
    assign mul_rd   = mrd[MUL_LAT-1];
    assign mul_d    = md[MUL_LAT-1];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            skid_v  <= 1'b0;
            skid_rd <= '0;
            skid_d  <= '0;
        end else if (g_skid || !skid_v) begin
            skid_v <= alu_blk;
            if (alu_blk) begin
                skid_rd <= alu_rd;
                skid_d  <= alu_d;
            end
        end
    end
`else
    logic unused_lat;

    assign unused_lat = MUL_LAT[0];
    assign mul_done   = 1'b0;
    assign mul_rd     = '0;
    assign mul_d      = '0;
    assign skid_v     = 1'b0;
    assign skid_rd    = '0;
    assign skid_d     = '0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus.ex_mem_valid      <= 1'b0;
            bus.ex_mem_addr       <= '0;
            bus.ex_mem_wdata      <= '0;
            bus.ex_mem_readmem    <= 1'b0;
            bus.ex_mem_writemem   <= 1'b0;
            bus.ex_mem_selwsource <= 1'b0;
            bus.ex_mem_regdest    <= '0;
            bus.ex_mem_writereg   <= 1'b0;
        end else begin
            bus.ex_mem_valid <= fire && is_mem;
            if (fire && is_mem) begin
                bus.ex_mem_addr       <= bus.is_ex_rega + bus.is_ex_imedext;
                bus.ex_mem_wdata      <= bus.is_ex_regb;
                bus.ex_mem_readmem    <= bus.is_ex_readmem;
                bus.ex_mem_writemem   <= bus.is_ex_writemem;
                bus.ex_mem_selwsource <= bus.is_ex_selwsource;
                bus.ex_mem_regdest    <= bus.is_ex_regdest;
                bus.ex_mem_writereg   <= bus.is_ex_writereg;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus.ex_overflow <= 1'b0;
            bus.ex_illegal  <= 1'b0;
        end else begin
            bus.ex_overflow <= fire && is_alu && ovf;
`ifdef EX_MULT_EN
            bus.ex_illegal  <= 1'b0;
`else
            bus.ex_illegal  <= fire && is_mul;
`endif
        end
    end

    assign bus.ex_is_stall   = skid_v;
    assign bus.ex_wb_valid   = wb_v;
    assign bus.ex_wb_regdest = wb_rd;
    assign bus.ex_wb_data    = wb_d;
    assign bus.ex_sb_clr     = wb_v;
    assign bus.ex_sb_addr    = wb_rd;

endmodule
